// File: rtl/rd_addsub_pipe.sv
// rd_addsub_pipe: pipelined add/subtract with a log-depth parallel-prefix carry network
module rd_addsub_pipe #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int LOG = $clog2(WIDTH);

    // Extended index 0 holds the effective carry-in; index i+1 holds operand bit i.
    // A bit with g=0,p=0 is a kill.
    logic [WIDTH:0]   gs [0:LOG];
    logic [WIDTH:0]   ps [0:LOG];
    logic [WIDTH:0]   gn [0:LOG-1];
    logic [WIDTH:0]   pn [0:LOG-1];
    logic [WIDTH-1:0] hs [0:LOG];
    logic [LOG:0]     vs, am, bm;
    logic [WIDTH-1:0] bx, s_n;
    logic             ci, advance, cout_n, ovf_n;

    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance;
    assign bx       = mode ? ~b : b;
    assign ci       = mode ? 1'b1 : cin;

    // Recursive doubling: level k merges each group with the one 2^k positions below it.
    always_comb begin
        for (int k = 0; k < LOG; k++) begin
            gn[k] = gs[k] | (ps[k] & (gs[k] << (1 << k)));
            pn[k] = ps[k] & ((ps[k] << (1 << k)) | ~({(WIDTH+1){1'b1}} << (1 << k)));
        end
    end

    // Final stage: resolved carry into each bit lives at the same extended index.
    always_comb begin
        s_n    = hs[LOG] ^ gs[LOG][WIDTH-1:0];
        cout_n = gs[LOG][WIDTH] | (ps[LOG][WIDTH] & gs[LOG][0]);
        ovf_n  = (am[LOG] == bm[LOG]) & (s_n[WIDTH-1] != am[LOG]);
    end

    // Whole pipeline shifts together on advance and freezes otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vs        <= '0;
            am        <= '0;
            bm        <= '0;
            for (int k = 0; k <= LOG; k++) begin
                gs[k] <= '0;
                ps[k] <= '0;
                hs[k] <= '0;
            end
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (advance) begin
            vs        <= {vs[LOG-1:0], in_valid};
            am        <= {am[LOG-1:0], a[WIDTH-1]};
            bm        <= {bm[LOG-1:0], bx[WIDTH-1]};
            gs[0]     <= {a & bx, ci};
            ps[0]     <= {a ^ bx, 1'b0};
            hs[0]     <= a ^ bx;
            for (int k = 0; k < LOG; k++) begin
                gs[k+1] <= gn[k];
                ps[k+1] <= pn[k];
                hs[k+1] <= hs[k];
            end
            out_valid <= vs[LOG];
            sum       <= s_n;
            cout      <= cout_n;
            ovf       <= ovf_n;
            zero      <= (s_n == '0);
        end
    end
endmodule

// File: tb/tb_rd_addsub_pipe.sv
// tb_rd_addsub_pipe: directed and randomized checks of rd_addsub_pipe against a reference model
module tb_rd_addsub_pipe;
    localparam int W    = 64;
    localparam int LAT  = 8;
    localparam int LAT8 = 5;

    logic clk = 1'b0, reset = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid = 1'b0, cin = 1'b0, mode = 1'b0, out_ready = 1'b1;
    logic [W-1:0] a = '0, b = '0;
    logic         in_ready, out_valid, cout, ovf, zero;
    logic [W-1:0] sum;

    logic         in_valid8 = 1'b0, cin8 = 1'b0, mode8 = 1'b0, out_ready8 = 1'b1;
    logic [7:0]   a8 = '0, b8 = '0;
    logic         in_ready8, out_valid8, cout8, ovf8, zero8;
    logic [7:0]   sum8;

    rd_addsub_pipe #(.WIDTH(W)) u64 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .mode(mode), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    rd_addsub_pipe #(.WIDTH(8)) u8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .mode(mode8), .out_valid(out_valid8),
        .out_ready(out_ready8), .sum(sum8), .cout(cout8), .ovf(ovf8), .zero(zero8)
    );

    int checks = 0, errors = 0;
    logic [W+2:0] q[$];
    int sent = 0, got = 0, bubbles = 0;
    bit started = 1'b0, held = 1'b0;
    logic [W+2:0] prev = '0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Expected {sum, cout, ovf, zero} from plain arithmetic on the operands.
    function automatic logic [W+2:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci, input logic md);
        logic [W:0] f;
        logic       v;
        if (md) begin
            f    = {1'b0, x} - {1'b0, y};
            f[W] = (x >= y);
            v    = (x[W-1] != y[W-1]) && (f[W-1] != x[W-1]);
        end else begin
            f = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
            v = (x[W-1] == y[W-1]) && (f[W-1] != x[W-1]);
        end
        return {f[W-1:0], f[W], v, f[W-1:0] == '0};
    endfunction

    function automatic logic [W-1:0] rnd();
        case ($urandom_range(0, 7))
            0: return '1;
            1: return '0;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // One cycle of the 64-bit stream: check outputs, drive inputs, update scoreboard.
    task automatic tick(input bit rand_rdy, input bit send);
        logic [W+2:0] obs;
        obs = {sum, cout, ovf, zero};
        if (held) begin
            check("stall_valid", out_valid, 1);
            check("stall_data", obs, prev);
        end
        if (out_valid) begin
            check("have_expected", q.size() != 0, 1);
            if (q.size() != 0) check("result", obs, q[0]);
        end else if (started && got < 100) bubbles++;
        if (out_valid) started = 1'b1;
        out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        in_valid  = send;
        if (send) begin
            a    = rnd();
            b    = rnd();
            cin  = 1'($urandom);
            mode = 1'($urandom);
        end
        #1;
        held = out_valid && !out_ready;
        prev = obs;
        if (out_valid && out_ready) begin
            got++;
            if (q.size() != 0) void'(q.pop_front());
        end
        if (in_valid && in_ready) begin
            q.push_back(model(a, b, cin, mode));
            sent++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic op64(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic md);
        a = x; b = y; cin = ci; mode = md; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        repeat (LAT - 2) cyc();
        check("lat64_early", out_valid, 0);
        cyc();
        check("lat64_valid", out_valid, 1);
    endtask

    task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic md);
        a8 = x; b8 = y; cin8 = 1'b0; mode8 = md; in_valid8 = 1'b1;
        cyc();
        in_valid8 = 1'b0;
        repeat (LAT8 - 2) cyc();
        check("lat8_early", out_valid8, 0);
        cyc();
        check("lat8_valid", out_valid8, 1);
    endtask

    initial begin
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_flags", {sum, cout, ovf, zero}, 0);
        check("rst8_all", {out_valid8, sum8, cout8, ovf8, zero8}, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        op64('1, 64'd1, 1'b0, 1'b0);
        check("carry_wrap", {sum, cout, ovf, zero}, {64'h0, 1'b1, 1'b0, 1'b1});
        cyc();
        op64(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        check("signed_ovf", {sum, cout, ovf, zero}, {64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0});
        cyc();
        op64(64'd10, 64'd3, 1'b1, 1'b1);
        check("sub_ignores_cin", {sum, cout, ovf, zero}, {64'd7, 1'b1, 1'b0, 1'b0});
        cyc();
        op8(8'h05, 8'h07, 1'b1);
        check("sub8_neg", {sum8, cout8, ovf8, zero8}, {8'hFE, 1'b0, 1'b0, 1'b0});
        cyc();
        op8(8'h80, 8'h01, 1'b1);
        check("sub8_ovf", {sum8, cout8, ovf8, zero8}, {8'h7F, 1'b1, 1'b1, 1'b0});
        cyc();
        check("idle_out_valid", out_valid, 0);

        sent = 0; got = 0; bubbles = 0; started = 1'b0;
        for (int n = 0; n < 100; n++) tick(0, 1);
        for (int n = 0; n < LAT + 20 && q.size() != 0; n++) tick(0, 0);
        check("stream_sent", sent, 100);
        check("stream_got", got, 100);
        check("stream_bubbles", bubbles, 0);
        check("stream_drained", q.size(), 0);

        sent = 0; got = 0; started = 1'b0;
        for (int n = 0; n < 300; n++) tick(1, 1);
        for (int n = 0; n < 4 * LAT + 40 && q.size() != 0; n++) tick(1, 0);
        check("bp_drained", q.size(), 0);
        check("bp_count", got, sent);
        for (int n = 0; n < 3; n++) tick(0, 0);
        check("bp_idle", out_valid, 0);

        held = 1'b0;
        for (int n = 0; n < 3; n++) tick(0, 1);
        for (int n = 0; n < 3; n++) tick(0, 0);
        #2 reset = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_ready", in_ready, 1);
        check("async_rst_flags", {sum, cout, ovf, zero}, 0);
        q.delete();
        @(negedge clk);
        reset = 1'b1;
        for (int n = 0; n < LAT + 4; n++) begin
            check("no_ghost", out_valid, 0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
